aoi_pipe: RTL and testbench
===========================

Name: aoi_pipe

Overview:
- Parametrised, pipelined And-Or-Invert array. Combines GROUPS product terms of TERM_IN operands each, bitwise across WIDTH lanes.
- Supports four logic modes, chosen per transaction: AOI, AO, OAI, OA.
- Two register stages with a valid/ready handshake on both sides, plus a counter of completed transactions.
- Intended as the reusable complex-gate datapath element; with GROUPS=2, TERM_IN=2, WIDTH=1 in AOI mode it computes y = ~((a&b)|(c&d)).

Parameters:
- WIDTH, 8, number of independent bit lanes per operand.
- GROUPS, 2, number of first-level terms (range 1..8).
- TERM_IN, 2, operands per first-level term (range 1..8).
- CNT_W, 16, width of the transaction counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_data/in_mode are valid this cycle.
- in_ready, output, 1, block accepts input this cycle.
- in_data, input, GROUPS*TERM_IN*WIDTH, flattened operands. Operand t of term g is in_data[((g*TERM_IN)+t)*WIDTH +: WIDTH].
- in_mode, input, 2, logic mode: 00 AOI, 01 AO, 10 OAI, 11 OA.
- out_valid, output, 1, out_data holds a result.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, WIDTH, result.
- op_count, output, CNT_W, number of completed output transfers.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, out_valid=0, out_data=0, op_count=0, all internal data/mode registers=0. in_ready reads 1 while in reset and after reset is released.
- Transfers: input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage-2 load enable: ld2 = !out_valid || out_ready.
- in_ready = !s1_valid || ld2. This is combinational from registered state and out_ready only; there is no path from in_valid.
- Stage 1, on input transfer:
  - term[g] = AND over t of operand(g,t) for modes 00/01; OR over t for modes 10/11.
  - Register all GROUPS terms (GROUPS*WIDTH bits) and the mode. Set s1_valid=1.
  - If no input transfer but stage 1 advances (s1_valid && ld2), clear s1_valid=0.
- Stage 2, when ld2:
  - out_valid <= s1_valid.
  - If s1_valid: comb = OR over g of term[g] (modes 00/01) or AND over g (modes 10/11). out_data <= comb, inverted for modes 00 and 10.
  - If !s1_valid, out_data holds its previous value.
- Latency: a result appears on out_data with out_valid=1 exactly 2 cycles after its input transfer, when there is no backpressure.
- Throughput: 1 transaction per cycle when out_ready is held high.
- Backpressure (out_valid && !out_ready):
  - out_data and out_valid hold stable.
  - Stage 1 holds. in_ready=0 if s1_valid=1.
  - Up to 2 transactions are buffered. No data is lost or duplicated.
- Mode travels with its data. Changing in_mode between transactions never affects a transaction already in flight.
- op_count increments by 1 on every output transfer and wraps from all-ones to 0.
- Simultaneous input and output transfer in the same cycle: both occur; occupancy is unchanged.
- Reset asserted mid-operation: all in-flight transactions are discarded immediately; no output transfer is reported afterwards.
- Degenerate parameters:
  - TERM_IN=1: each term is the operand itself.
  - GROUPS=1: the second-level OR/AND is a passthrough.

Test Plan:
1. Defaults, in_data=32'hAA0FCCF0 (a=F0, b=CC, c=0F, d=AA), in_mode=00, out_ready=1 -> 2 cycles later out_valid=1, out_data=8'h35; op_count=1.
2. Same data with in_mode 01, 10, 11 on consecutive cycles -> outputs CA, 53, AC on consecutive cycles, in order; op_count=3.
3. out_ready=0, then 3 back-to-back inputs -> first two accepted, third sees in_ready=0. out_data holds its first result. Release out_ready -> all 3 results delivered in order, none lost.
4. Simultaneous input and output transfer on every cycle for 10 cycles -> 10 results in order, each with 2-cycle latency, in_ready continuously 1.
5. rst_n pulsed low while 2 transactions are in flight -> out_valid=0, out_data=0, op_count=0 immediately (asynchronously); no stale output appears after release.
6. CNT_W=4, 17 transfers -> op_count wraps 15->0 and ends at 1. Separately, GROUPS=2, TERM_IN=2, WIDTH=1, mode 00 -> exhaustive 16-vector sweep matches ~((a&b)|(c&d)).

Source files
------------

// File: rtl/aoi_pipe_if.sv
// Handshake bundle for aoi_pipe: operand/mode request side and result/count response side.
// The block itself is the slave; the producer/consumer pair around it is the master.
interface aoi_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int GROUPS  = 2,
  parameter int TERM_IN = 2,
  parameter int CNT_W   = 16
);
  logic                              in_valid;
  logic                              in_ready;
  logic [GROUPS*TERM_IN*WIDTH-1:0]   in_data;
  logic [1:0]                        in_mode;
  logic                              out_valid;
  logic                              out_ready;
  logic [WIDTH-1:0]                  out_data;
  logic [CNT_W-1:0]                  op_count;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, op_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, op_count
  );
endinterface

// File: rtl/aoi_pipe.sv
// Pipelined AOI/AO/OAI/OA array; 2-cycle latency, one result per cycle.
// Backpressure: out stage holds on !out_ready, stage 1 holds behind it; in_ready drops only when both are full.
module aoi_pipe #(
  parameter int WIDTH   = 8,
  parameter int GROUPS  = 2,
  parameter int TERM_IN = 2,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  aoi_pipe_if.slave   bus
);

  // Mode travels alongside the first-level terms so in-flight results never see a later in_mode.
  typedef struct packed {
    logic [1:0]                    mode;
    logic [GROUPS-1:0][WIDTH-1:0]  terms;
  } s1_t;

  s1_t              s1_d;
  s1_t              s1_q;
  logic             s1_valid;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] comb;
  logic [CNT_W-1:0] op_count_q;
  logic             ld2;
  logic             in_xfer;
  logic             out_xfer;

  assign ld2      = !out_valid_q || bus.out_ready;
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

  assign bus.in_ready  = !s1_valid || ld2;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.op_count  = op_count_q;

  // mode[1] selects OR-terms / AND-combine; mode[0]=0 selects the inverted output.
  always_comb begin
    s1_d      = '0;
    s1_d.mode = bus.in_mode;
    for (int g = 0; g < GROUPS; g++) begin
      s1_d.terms[g] = bus.in_mode[1] ? '0 : '1;
      for (int t = 0; t < TERM_IN; t++) begin
        if (bus.in_mode[1])
          s1_d.terms[g] = s1_d.terms[g] | bus.in_data[((g*TERM_IN)+t)*WIDTH +: WIDTH];
        else
          s1_d.terms[g] = s1_d.terms[g] & bus.in_data[((g*TERM_IN)+t)*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    comb = s1_q.mode[1] ? '1 : '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (s1_q.mode[1])
        comb = comb & s1_q.terms[g];
      else
        comb = comb | s1_q.terms[g];
    end
    if (!s1_q.mode[0])
      comb = ~comb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      op_count_q  <= '0;
    end else begin
      if (in_xfer) begin
        s1_q     <= s1_d;
        s1_valid <= 1'b1;
      end else if (ld2) begin
        s1_valid <= 1'b0;
      end

      if (ld2) begin
        out_valid_q <= s1_valid;
        if (s1_valid)
          out_data_q <= comb;
      end

      if (out_xfer)
        op_count_q <= op_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aoi_pipe.sv
// Scoreboard bench for aoi_pipe: default instance for modes/backpressure/reset,
// small 1-bit CNT_W=4 instance for the truth-table sweep and counter wrap.
module tb_aoi_pipe;

  typedef struct {
    logic [7:0] data;
    int         cyc;
    bit         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q_a[$];
  logic q_b[$];
  exp_t e_a;
  logic e_b;

  aoi_pipe_if #(.WIDTH(8), .GROUPS(2), .TERM_IN(2), .CNT_W(16)) bus_a ();
  aoi_pipe_if #(.WIDTH(1), .GROUPS(2), .TERM_IN(2), .CNT_W(4))  bus_b ();

  aoi_pipe #(.WIDTH(8), .GROUPS(2), .TERM_IN(2), .CNT_W(16)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  aoi_pipe #(.WIDTH(1), .GROUPS(2), .TERM_IN(2), .CNT_W(4)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_fn(input logic [31:0] d, input logic [1:0] m);
    logic [7:0] a, b, c, e;
    a = d[7:0]; b = d[15:8]; c = d[23:16]; e = d[31:24];
    case (m)
      2'b00:   ref_fn = ~((a & b) | (c & e));
      2'b01:   ref_fn =  ((a & b) | (c & e));
      2'b10:   ref_fn = ~((a | b) & (c | e));
      default: ref_fn =  ((a | b) & (c | e));
    endcase
  endfunction

  // Monitors: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_output actual=%h expected=none", bus_a.out_data);
      end else begin
        e_a = q_a.pop_front();
        chk("a_out_data", {24'h0, bus_a.out_data}, {24'h0, e_a.data});
        if (e_a.lat)
          chk("a_latency", cyc - e_a.cyc, 2);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_b.out_valid === 1'b1 && bus_b.out_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_output actual=%b expected=none", bus_b.out_data);
      end else begin
        e_b = q_b.pop_front();
        chk("b_out_data", {31'h0, bus_b.out_data}, {31'h0, e_b});
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic [1:0] m, input logic [7:0] exp,
                        input bit lat, output int waited);
    exp_t e;
    waited = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_mode  = m;
    @(negedge clk);
    while (bus_a.in_ready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (bus_a.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL a_in_ready_timeout actual=%b expected=1", bus_a.in_ready);
      bus_a.in_valid = 1'b0;
    end else begin
      e.data = exp; e.cyc = cyc; e.lat = lat;
      q_a.push_back(e);
      @(posedge clk); #1;
      bus_a.in_valid = 1'b0;
    end
  endtask

  task automatic send_b(input logic [3:0] d);
    int waited = 0;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = d;
    bus_b.in_mode  = 2'b00;
    @(negedge clk);
    while (bus_b.in_ready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (bus_b.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL b_in_ready_timeout actual=%b expected=1", bus_b.in_ready);
      bus_b.in_valid = 1'b0;
    end else begin
      q_b.push_back(~((d[0] & d[1]) | (d[2] & d[3])));
      @(posedge clk); #1;
      bus_b.in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    @(negedge clk);
    while ((q_a.size() > 0 || q_b.size() > 0) && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (q_a.size() > 0 || q_b.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout actual=%0d expected=0", name, q_a.size() + q_b.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q_a.delete();
    q_b.delete();
    rst_n = 1'b1;
  endtask

  logic [31:0] vec4 [10];
  int          w;
  int          w2;

  initial begin
    rst_n           = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.in_mode   = 2'b00;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = '0;
    bus_b.in_mode   = 2'b00;
    bus_b.out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    chk("rst_out_valid", {31'h0, bus_a.out_valid}, 0);
    chk("rst_out_data",  {24'h0, bus_a.out_data}, 0);
    chk("rst_op_count",  {16'h0, bus_a.op_count}, 0);
    chk("rst_in_ready",  {31'h0, bus_a.in_ready}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'h0, bus_a.in_ready}, 1);

    // 1: single AOI transaction
    send_a(32'hAA0FCCF0, 2'b00, 8'h35, 1'b1, w);
    drain("t1");
    chk("t1_op_count", {16'h0, bus_a.op_count}, 1);

    // 2: all modes back to back
    do_reset();
    send_a(32'hAA0FCCF0, 2'b01, 8'hCA, 1'b1, w);
    send_a(32'hAA0FCCF0, 2'b10, 8'h53, 1'b1, w);
    send_a(32'hAA0FCCF0, 2'b11, 8'hAC, 1'b1, w);
    drain("t2");
    chk("t2_op_count", {16'h0, bus_a.op_count}, 3);

    // 3: backpressure, two buffered, third stalled
    do_reset();
    bus_a.out_ready = 1'b0;
    send_a(32'h12345678, 2'b00, ref_fn(32'h12345678, 2'b00), 1'b0, w);
    send_a(32'hDEADBEEF, 2'b01, ref_fn(32'hDEADBEEF, 2'b01), 1'b0, w2);
    chk("t3_first_two_accepted", w + w2, 0);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 32'h0F0FF0F0;
    bus_a.in_mode  = 2'b10;
    @(negedge clk);
    chk("t3_in_ready_low",  {31'h0, bus_a.in_ready}, 0);
    chk("t3_out_valid",     {31'h0, bus_a.out_valid}, 1);
    chk("t3_out_data_hold", {24'h0, bus_a.out_data}, {24'h0, ref_fn(32'h12345678, 2'b00)});
    @(negedge clk);
    chk("t3_out_data_hold2", {24'h0, bus_a.out_data}, {24'h0, ref_fn(32'h12345678, 2'b00)});
    chk("t3_in_ready_low2",  {31'h0, bus_a.in_ready}, 0);
    @(posedge clk); #1;
    bus_a.out_ready = 1'b1;
    send_a(32'h0F0FF0F0, 2'b10, ref_fn(32'h0F0FF0F0, 2'b10), 1'b0, w);
    drain("t3");
    chk("t3_op_count", {16'h0, bus_a.op_count}, 3);

    // 4: full-throughput streaming
    do_reset();
    vec4[0] = 32'h00000000; vec4[1] = 32'hFFFFFFFF; vec4[2] = 32'h0123ABCD;
    vec4[3] = 32'hF0F00F0F; vec4[4] = 32'h55AA33CC; vec4[5] = 32'h80402010;
    vec4[6] = 32'hFEDCBA98; vec4[7] = 32'h13579BDF; vec4[8] = 32'hC3C33C3C;
    vec4[9] = 32'h7E817E81;
    for (int i = 0; i < 10; i++) begin
      send_a(vec4[i], 2'(i % 4), ref_fn(vec4[i], 2'(i % 4)), 1'b1, w);
      chk("t4_in_ready_cont", w, 0);
    end
    drain("t4");
    chk("t4_op_count", {16'h0, bus_a.op_count}, 10);

    // 5: async reset with two in flight
    send_a(32'h11223344, 2'b00, ref_fn(32'h11223344, 2'b00), 1'b0, w);
    send_a(32'h55667788, 2'b11, ref_fn(32'h55667788, 2'b11), 1'b0, w);
    bus_a.out_ready = 1'b0;
    #2;
    chk("t5_inflight_valid", {31'h0, bus_a.out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", {31'h0, bus_a.out_valid}, 0);
    chk("t5_rst_out_data",  {24'h0, bus_a.out_data}, 0);
    chk("t5_rst_op_count",  {16'h0, bus_a.op_count}, 0);
    q_a.delete();
    q_b.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_stale", {31'h0, bus_a.out_valid}, 0);
    end
    chk("t5_op_count_after", {16'h0, bus_a.op_count}, 0);

    // 6: 1-bit AOI truth table and 4-bit counter wrap
    do_reset();
    for (int v = 0; v < 16; v++) begin
      send_b(4'(v));
      if (v == 14) begin
        drain("t6_15");
        chk("t6_op_count_15", {28'h0, bus_b.op_count}, 15);
      end
    end
    drain("t6_16");
    chk("t6_op_count_wrap", {28'h0, bus_b.op_count}, 0);
    send_b(4'b1011);
    drain("t6_17");
    chk("t6_op_count_end", {28'h0, bus_b.op_count}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
